aes_key_schedule_ctrl: RTL and testbench
========================================

Name: aes_key_schedule_ctrl

Overview:
Iterative AES-128 key-expansion sequencer. Accepts a 128-bit cipher key over a valid/ready handshake and steps a single-round key-step function once per clock for rounds 0..9. Stores all 11 round keys (round 0 = cipher key) in an internal register bank. Serves any round key to the downstream cipher round datapath through a random-access read port.

Parameters:
NUM_ROUNDS, 10, number of expansion rounds; the bank holds NUM_ROUNDS+1 keys. Only 10 is supported for AES-128.
KEY_W, 128, key width in bits. Fixed at 128.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
key_valid  input  1  cipher key present on key_in.
key_in  input  128  cipher key, word w0 in [127:96].
key_ready  output  1  block can accept a new key.
busy  output  1  expansion in progress.
done  output  1  one-cycle pulse when all round keys are valid.
keys_valid  output  1  bank holds a complete, consistent schedule.
rk_idx  input  4  round-key read index, 0..10.
rk_out  output  128  round key at rk_idx.

Behaviour:
- Reset: asynchronous on rst_n low, state-independent.
  - Outputs: key_ready=0 while rst_n low, then 1 in IDLE; busy=0, done=0, keys_valid=0.
  - Internals: all bank entries cleared to 0, round counter cleared to 0.
- States and transitions:
  - IDLE -> EXPAND when key_valid && key_ready.
  - EXPAND -> EXPAND while the counter is below 9.
  - EXPAND -> DONE at counter 9.
  - DONE -> IDLE after one cycle.
- IDLE:
  - key_ready = 1.
  - On handshake at cycle T: bank[0] <= key_in, counter <= 0, keys_valid <= 0, enter EXPAND.
- EXPAND:
  - key_ready = 0 and busy = 1.
  - Each cycle: bank[counter+1] <= step(counter, bank[counter]), then counter++.
  - The step function is combinational: rotword/subword of w3 in its byte order, xor with Rcon(counter), running xor across w0..w3.
  - bank[1] is written at the end of cycle T+1 and bank[10] at the end of cycle T+10.
- DONE (cycle T+11):
  - done = 1 and keys_valid <= 1.
  - key_ready = 0 and busy = 0.
  - Next cycle returns to IDLE.
  - Handshake-to-done latency is exactly 11 cycles. A back-to-back key is accepted no earlier than T+12.
- Read port:
  - rk_out is combinational from bank[rk_idx], with no latency.
  - rk_idx 11..15 returns 128'h0.
  - Reads during EXPAND return the current partial contents. Consumers must gate reads on keys_valid.
- New key while keys_valid=1: keys_valid drops to 0 in the cycle after the handshake (T+1), and the old schedule is overwritten progressively.
- key_valid while busy: ignored with no effect. The source must hold the key until key_ready.
- Reset mid-EXPAND:
  - Bank cleared, keys_valid=0, state IDLE.
  - No done pulse is produced.
- Rcon indices 0..9 map to 01,02,04,08,10,20,40,80,1b,36 in the top byte. The counter never exceeds 9 in EXPAND.
- Bank writes occur only in IDLE (entry 0) and EXPAND (entries 1..10). There are no other writers.

Decomposition:
- Shared package aes_pkg holds:
  - KEY_W, NUM_ROUNDS, the Rcon table as a constant array, the SBOX table function, and the state enum (IDLE, EXPAND, DONE).
- One sub-module, aes_key_step:
  - Purely combinational (round[3:0], key_in[127:0]) -> key_out[127:0].
  - Instantiated once; the controller owns all state.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c:
  - done at handshake+11.
  - rk_idx=0 -> 2b7e1516..., rk_idx=1 -> a0fafe1788542cb123a339392a6c7605.
  - rk_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
- All-zero key -> rk_idx=1 = 62636363626363636263636362636363; rk_idx=10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- key_valid held high throughout expansion:
  - Exactly one key accepted.
  - key_ready low T+1..T+11.
  - Second key accepted at T+12; keys_valid=0 from T+13 until its done.
- rst_n pulsed low at handshake+5:
  - All outputs reset immediately; rk_out=0 for every idx.
  - No done pulse; a subsequent key completes normally.
- rk_idx sweep 11..15 after done -> rk_out=0. Valid idx 0..10 reads match the golden model.
- Reset-release check: key_ready=0 while rst_n=0, 1 on the first cycle after release; busy/done/keys_valid=0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants, tables and types for the AES-128 key-schedule block.
package aes_pkg;

  localparam int KEY_W      = 128;
  localparam int NUM_ROUNDS = 10;

  // Round constants, top byte of the Rcon word, indexed by expansion round 0..9.
  localparam logic [0:9][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Forward AES S-box, entry 0 in the most significant byte.
  localparam logic [0:255][7:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } state_e;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[b];
  endfunction

  // Rounds outside 0..9 never occur in use; return 0 rather than index past the table.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    return (r < 4'd10) ? RCON[r] : 8'h00;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion step: round key r -> round key r+1. Purely combinational.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [3:0]       round,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_out
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub, temp;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key_in;

  // RotWord moves the leading byte of w3 to the end, then SubWord byte by byte.
  assign rot  = {w3[23:0], w3[31:24]};
  assign sub  = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  assign temp = sub ^ {rcon(round), 24'h000000};

  // Running xor: each new word depends on the previous new word.
  assign n0 = w0 ^ temp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign key_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_schedule_ctrl.sv
// Iterative AES-128 key-expansion sequencer with an 11-entry round-key bank
// and a zero-latency random-access read port.
module aes_key_schedule_ctrl
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [KEY_W-1:0] key_in,
  output logic             key_ready,
  output logic             busy,
  output logic             done,
  output logic             keys_valid,
  input  logic [3:0]       rk_idx,
  output logic [KEY_W-1:0] rk_out
);

  localparam int         NUM_KEYS = NUM_ROUNDS + 1;
  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             keys_valid_q, keys_valid_d;
  logic [KEY_W-1:0] bank_q [NUM_KEYS];
  logic             bank_we;
  logic [3:0]       bank_widx;
  logic [KEY_W-1:0] bank_wdata;
  logic [KEY_W-1:0] step_out;

  // The single step instance always works on the most recently written key.
  aes_key_step u_step (
    .round   (cnt_q),
    .key_in  (bank_q[cnt_q]),
    .key_out (step_out)
  );

  // Control registers: state, round counter and schedule-complete flag.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      keys_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      keys_valid_q <= keys_valid_d;
    end
  end

  // Round-key bank: entry 0 loaded on handshake, entries 1..10 by the step function.
  // NOTE: the bank is flops, not RAM, so it is cleared on reset to guarantee zero reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_KEYS; i++) bank_q[i] <= '0;
    end else if (bank_we) begin
      bank_q[bank_widx] <= bank_wdata;
    end
  end

  // Next-state logic and the single bank write port.
  // NOTE: every output of this block gets a default first, so no latches are inferred.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    keys_valid_d = keys_valid_q;
    bank_we      = 1'b0;
    bank_widx    = 4'd0;
    bank_wdata   = '0;
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          state_d      = EXPAND;
          cnt_d        = 4'd0;
          keys_valid_d = 1'b0;
          bank_we      = 1'b1;
          bank_wdata   = key_in;
        end
      end
      EXPAND: begin
        bank_we    = 1'b1;
        bank_widx  = cnt_q + 4'd1;
        bank_wdata = step_out;
        if (cnt_q == LAST_RND) state_d = DONE;
        else                   cnt_d   = cnt_q + 4'd1;
      end
      DONE: begin
        keys_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // key_ready is forced low while reset is asserted even though the state is IDLE.
  assign key_ready  = rst_n && (state_q == IDLE);
  assign busy       = (state_q == EXPAND);
  assign done       = (state_q == DONE);
  assign keys_valid = keys_valid_q;

  assign rk_out = (rk_idx < 4'(NUM_KEYS)) ? bank_q[rk_idx] : '0;

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// Directed bench for the AES-128 key-schedule sequencer, FIPS-197 vectors.
module tb_aes_key_schedule_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_valid;
  logic [127:0] key_in;
  logic         key_ready;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] FIPS_RK [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_key_schedule_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_in     (key_in),
    .key_ready  (key_ready),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid),
    .rk_idx     (rk_idx),
    .rk_out     (rk_out)
  );

  always #5 clk = ~clk;

  // Every task starts and ends just after a rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key_valid = 1'b0; key_in = '0; rk_idx = 4'd0;
    repeat (2) @(negedge clk);
    checks++; if (key_ready !== 1'b0) begin failures++; $display("FAIL rst_key_ready got=%b exp=0", key_ready); end
    checks++; if ({busy, done, keys_valid} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {busy, done, keys_valid}); end
    checks++; if (rk_out !== '0) begin failures++; $display("FAIL rst_rk0 got=%h exp=0", rk_out); end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (key_ready !== 1'b1) begin failures++; $display("FAIL rel_key_ready got=%b exp=1", key_ready); end
    checks++; if ({busy, done, keys_valid} !== 3'b000) begin failures++; $display("FAIL rel_flags got=%b exp=000", {busy, done, keys_valid}); end
    next_cycle();
  endtask

  task automatic test_fips_key();
    key_in = FIPS_RK[0]; key_valid = 1'b1;
    @(negedge clk);
    checks++; if (key_ready !== 1'b1) begin failures++; $display("FAIL fips_hs_ready got=%b exp=1", key_ready); end
    next_cycle();
    key_valid = 1'b0; key_in = '0;
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      checks++; if (done !== (n == 11)) begin failures++; $display("FAIL fips_done cyc=%0d got=%b exp=%b", n, done, (n == 11)); end
      checks++; if (busy !== (n <= 10)) begin failures++; $display("FAIL fips_busy cyc=%0d got=%b exp=%b", n, busy, (n <= 10)); end
      checks++; if (key_ready !== 1'b0) begin failures++; $display("FAIL fips_ready cyc=%0d got=%b exp=0", n, key_ready); end
      next_cycle();
    end
    @(negedge clk);
    checks++; if (keys_valid !== 1'b1) begin failures++; $display("FAIL fips_keys_valid got=%b exp=1", keys_valid); end
    checks++; if (key_ready !== 1'b1) begin failures++; $display("FAIL fips_idle_ready got=%b exp=1", key_ready); end
    for (int i = 0; i <= 10; i++) begin
      rk_idx = 4'(i); #1;
      checks++; if (rk_out !== FIPS_RK[i]) begin failures++; $display("FAIL fips_rk idx=%0d got=%h exp=%h", i, rk_out, FIPS_RK[i]); end
    end
    for (int i = 11; i <= 15; i++) begin
      rk_idx = 4'(i); #1;
      checks++; if (rk_out !== '0) begin failures++; $display("FAIL rk_oob idx=%0d got=%h exp=0", i, rk_out); end
    end
    next_cycle();
  endtask

  task automatic test_zero_key();
    int done_cyc = -1;
    key_in = '0; key_valid = 1'b1;
    next_cycle();
    key_valid = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (done && done_cyc < 0) done_cyc = n;
      next_cycle();
    end
    checks++; if (done_cyc !== 11) begin failures++; $display("FAIL zero_done_latency got=%0d exp=11", done_cyc); end
    rk_idx = 4'd0; #1;
    checks++; if (rk_out !== '0) begin failures++; $display("FAIL zero_rk0 got=%h exp=0", rk_out); end
    rk_idx = 4'd1; #1;
    checks++; if (rk_out !== ZERO_RK1) begin failures++; $display("FAIL zero_rk1 got=%h exp=%h", rk_out, ZERO_RK1); end
    rk_idx = 4'd10; #1;
    checks++; if (rk_out !== ZERO_RK10) begin failures++; $display("FAIL zero_rk10 got=%h exp=%h", rk_out, ZERO_RK10); end
    next_cycle();
  endtask

  // key_valid stays high across a whole expansion: first key at T, second at T+12.
  task automatic test_back_to_back();
    int hs_early = 0;
    int hs_total = 0;
    int hs_second = -1;
    rk_idx = 4'd10;
    key_in = '0; key_valid = 1'b1;
    for (int n = 0; n <= 24; n++) begin
      @(negedge clk);
      if (key_valid && key_ready) begin
        hs_total++;
        if (n <= 11) hs_early++;
        if (n > 0 && hs_second < 0) hs_second = n;
      end
      if (n >= 1 && n <= 11) begin
        checks++; if (key_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready cyc=%0d got=%b exp=0", n, key_ready); end
      end
      if (n == 12) begin
        checks++; if (keys_valid !== 1'b1) begin failures++; $display("FAIL b2b_kv_first got=%b exp=1", keys_valid); end
        checks++; if (rk_out !== ZERO_RK10) begin failures++; $display("FAIL b2b_first_rk10 got=%h exp=%h", rk_out, ZERO_RK10); end
      end
      if (n >= 13 && n <= 23) begin
        checks++; if (keys_valid !== 1'b0) begin failures++; $display("FAIL b2b_kv_low cyc=%0d got=%b exp=0", n, keys_valid); end
      end
      if (n == 23) begin
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_second_done got=%b exp=1", done); end
      end
      if (n == 24) begin
        checks++; if (keys_valid !== 1'b1) begin failures++; $display("FAIL b2b_kv_second got=%b exp=1", keys_valid); end
        checks++; if (rk_out !== FIPS_RK[10]) begin failures++; $display("FAIL b2b_second_rk10 got=%h exp=%h", rk_out, FIPS_RK[10]); end
      end
      next_cycle();
      if (n == 0)  key_in = FIPS_RK[0];
      if (n == 12) key_valid = 1'b0;
    end
    checks++; if (hs_early !== 1) begin failures++; $display("FAIL b2b_one_accept got=%0d exp=1", hs_early); end
    checks++; if (hs_second !== 12) begin failures++; $display("FAIL b2b_second_accept got=%0d exp=12", hs_second); end
    checks++; if (hs_total !== 2) begin failures++; $display("FAIL b2b_total_accepts got=%0d exp=2", hs_total); end
  endtask

  task automatic test_reset_mid_expand();
    int saw_done = 0;
    int done_cyc = -1;
    key_in = FIPS_RK[0]; key_valid = 1'b1;
    next_cycle();
    key_valid = 1'b0;
    repeat (4) next_cycle();
    rst_n = 1'b0;
    #1;
    checks++; if ({key_ready, busy, done, keys_valid} !== 4'b0000) begin failures++; $display("FAIL mid_rst_outputs got=%b exp=0000", {key_ready, busy, done, keys_valid}); end
    for (int i = 0; i <= 15; i++) begin
      rk_idx = 4'(i); #1;
      checks++; if (rk_out !== '0) begin failures++; $display("FAIL mid_rst_rk idx=%0d got=%h exp=0", i, rk_out); end
    end
    next_cycle();
    rst_n = 1'b1;
    for (int n = 0; n < 14; n++) begin
      @(negedge clk);
      if (done) saw_done = 1;
      next_cycle();
    end
    checks++; if (saw_done !== 0) begin failures++; $display("FAIL mid_rst_no_done got=%0d exp=0", saw_done); end
    checks++; if (key_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_idle got=%b exp=1", key_ready); end
    key_in = FIPS_RK[0]; key_valid = 1'b1;
    next_cycle();
    key_valid = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (done && done_cyc < 0) done_cyc = n;
      next_cycle();
    end
    checks++; if (done_cyc !== 11) begin failures++; $display("FAIL mid_rst_recover_done got=%0d exp=11", done_cyc); end
    checks++; if (keys_valid !== 1'b1) begin failures++; $display("FAIL mid_rst_recover_kv got=%b exp=1", keys_valid); end
    rk_idx = 4'd5; #1;
    checks++; if (rk_out !== FIPS_RK[5]) begin failures++; $display("FAIL mid_rst_recover_rk5 got=%h exp=%h", rk_out, FIPS_RK[5]); end
    rk_idx = 4'd10; #1;
    checks++; if (rk_out !== FIPS_RK[10]) begin failures++; $display("FAIL mid_rst_recover_rk10 got=%h exp=%h", rk_out, FIPS_RK[10]); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_fips_key();
    test_zero_key();
    test_back_to_back();
    test_reset_mid_expand();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
